// File: rtl/req_serializer128.sv
// Serializes a request vector into one-hot words, lowest set bit first.
// Each word carries its binary index and a last-bit flag.
module req_serializer128 #(
  parameter int WIDTH = 128,
  parameter int IDXW  = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a word is held until taken.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [WIDTH-1:0] lowest;
  logic [IDXW-1:0]  lowest_idx;
  logic             single;

  // Two's-complement trick isolates the lowest set bit.
  assign lowest = pending & (~pending + WIDTH'(1));
  assign single = (pending & (pending - WIDTH'(1))) == '0;

  always_comb begin
    lowest_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lowest[i]) lowest_idx = IDXW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE: begin
        if (in_valid) begin
          // An all-zero vector is accepted and dropped without a word.
          pending_next = in_req;
          state_next   = (in_req != '0) ? BUSY : IDLE;
        end
      end
      BUSY: begin
        if (out_ready) begin
          pending_next = pending & ~lowest;
          if (single) state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == BUSY);
    out_onehot = out_valid ? lowest : '0;
    out_index  = out_valid ? lowest_idx : '0;
    out_last   = out_valid & single;
  end

endmodule

// File: tb/tb_req_serializer128.sv
// Directed bench for req_serializer128: driver tasks push expected words,
// a negedge monitor pops and compares every word the DUT presents.
module tb_req_serializer128;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_req;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_onehot;
  logic [6:0]   out_index;
  logic         out_last;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected word: {last, index}
  logic [7:0] exp_q[$];

  req_serializer128 #(.WIDTH(128), .IDXW(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_req     (in_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_index  (out_index),
    .out_last   (out_last)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic last);
    exp_q.push_back({last, 7'(idx)});
  endtask

  task automatic send(input logic [127:0] vec);
    int budget;
    budget = 0;
    while (!in_ready && budget < 300) begin
      cyc();
      budget++;
    end
    check("send_ready", {127'b0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_req   = vec;
    cyc();
    in_valid = 1'b0;
    in_req   = '0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (!(exp_q.size() == 0 && in_ready) && budget < 300) begin
      cyc();
      budget++;
    end
    check(name, {96'b0, 32'(exp_q.size()), 31'b0, in_ready}, {96'b0, 32'd0, 31'b0, 1'b1});
  endtask

  task automatic check_idle(input string name);
    check({name, "_in_ready"}, {127'b0, in_ready}, 128'd1);
    check({name, "_out_valid"}, {127'b0, out_valid}, 128'd0);
    check({name, "_onehot"}, out_onehot, 128'd0);
    check({name, "_index"}, {121'b0, out_index}, 128'd0);
    check({name, "_last"}, {127'b0, out_last}, 128'd0);
  endtask

  // Scoreboard monitor: compares the head word every valid cycle, pops on handshake
  always @(negedge clock) begin
    logic [7:0]   e;
    logic [127:0] one;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        if (out_ready) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_word: got index %0d expected none", out_index);
        end
      end else begin
        e   = exp_q[0];
        one = 128'd1;
        check("mon_index", {121'b0, out_index}, {121'b0, e[6:0]});
        check("mon_onehot", out_onehot, one << e[6:0]);
        check("mon_last", {127'b0, out_last}, {127'b0, e[7]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [127:0] v;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_req    = '0;
    out_ready = 1'b1;
    repeat (2) cyc();
    check_idle("reset");
    reset = 1'b0;
    repeat (3) cyc();
    check_idle("idle_hold");

    // Single top bit: one word, then back to idle
    v = 128'd1 << 127;
    send(v);
    push_exp(127, 1'b1);
    check("single_valid", {127'b0, out_valid}, 128'd1);
    cyc();
    check_idle("single_after");
    drain("single_drain");

    // Multi-bit ordering: bits 0, 2, 16, 127
    v = (128'd1 << 127) | 128'h1_0005;
    send(v);
    push_exp(0, 1'b0);
    push_exp(2, 1'b0);
    push_exp(16, 1'b0);
    push_exp(127, 1'b1);
    drain("multi_drain");

    // Backpressure: index 1 held for three stalled cycles
    out_ready = 1'b0;
    send(128'h6);
    push_exp(1, 1'b0);
    push_exp(2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_index", {121'b0, out_index}, 128'd1);
      check("bp_hold_onehot", out_onehot, 128'h2);
      cyc();
    end
    out_ready = 1'b1;
    drain("bp_drain");

    // Zero vector is swallowed
    send(128'd0);
    check_idle("zero_after");
    cyc();
    check_idle("zero_after2");

    // in_valid during BUSY is ignored
    out_ready = 1'b0;
    send(128'h3);
    push_exp(0, 1'b0);
    push_exp(1, 1'b1);
    in_valid = 1'b1;
    in_req   = 128'hF0;
    repeat (2) cyc();
    check("busy_in_ready", {127'b0, in_ready}, 128'd0);
    in_valid  = 1'b0;
    in_req    = '0;
    out_ready = 1'b1;
    drain("busy_drain");
    repeat (3) cyc();
    check_idle("busy_after");

    // Reset mid-vector after five words
    send({128{1'b1}});
    for (int i = 0; i < 5; i++) push_exp(i, 1'b0);
    repeat (5) cyc();
    check("midrst_queue", {96'b0, 32'(exp_q.size())}, 128'd0);
    out_ready = 1'b0;
    reset     = 1'b1;
    cyc();
    reset = 1'b0;
    check_idle("midrst_after");
    out_ready = 1'b1;
    send(128'h8);
    push_exp(3, 1'b1);
    drain("midrst_drain");
    repeat (3) cyc();
    check_idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/req_serializer128.md
# req_serializer128

Upstream feeder for the 128-bit encode/decode channel. Accepts a 128-bit request vector through a valid/ready handshake and emits its set bits one at a time, lowest index first, as one-hot 128-bit words. Each output word drives the channel's `datain`. A 7-bit companion index is produced alongside, so the verifier can check the encoder result directly.

## Interface
Parameters:
- `WIDTH`, default 128: request/one-hot width. Fixed at 128 to match the channel.
- `IDXW`, default 7: index width, equal to log2(`WIDTH`).

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_req` is valid.
- `in_ready`  out  1  block can accept a vector. Equals the IDLE state.
- `in_req`  in  128  request vector.
- `out_valid`  out  1  `out_onehot`/`out_index` are valid. Equals the BUSY state.
- `out_ready`  in  1  consumer accepts the current word.
- `out_onehot`  out  128  lowest set bit of the pending vector.
- `out_index`  out  7  binary index of the bit in `out_onehot`.
- `out_last`  out  1  high when `out_onehot` is the final remaining bit.

## Operation
- State:
  - `pending[127:0]` register.
  - two-state FSM, IDLE / BUSY.
- Reset (synchronous, highest priority):
  - `pending` = 0, state = IDLE.
  - Outputs after the reset edge: `in_ready`=1, `out_valid`=0, `out_onehot`=0, `out_index`=0, `out_last`=0.
- IDLE: `in_ready`=1, `out_valid`=0.
  - On `in_valid`=1 with `in_req`≠0: `pending` ← `in_req`, go to BUSY.
  - On `in_valid`=1 with `in_req`=0: the vector is accepted and discarded. Stay in IDLE; no output word is produced.
- BUSY: `in_ready`=0, `out_valid`=1.
  - `out_onehot` = `pending & (~pending + 1)`.
  - `out_index` = position of that bit.
  - `out_last` = 1 when `pending` has exactly one bit set.
  - On `out_ready`=1, clear the emitted bit in `pending`. If that bit was the last one (`out_last`=1), go to IDLE.
  - On `out_ready`=0, hold all outputs stable. `out_onehot`, `out_index` and `out_last` must not change while `out_valid`=1 and `out_ready`=0.
- In IDLE, `out_onehot`, `out_index` and `out_last` are forced to 0. `pending` is 0 in IDLE.
- `in_req` is ignored whenever `in_ready`=0. `in_valid` during BUSY has no effect.
- Reset mid-vector: the remaining bits are dropped. The next cycle is IDLE with the reset values above.

## Timing
- Accept latency: vector accepted at edge N gives `out_valid`=1 in cycle N+1, carrying the lowest bit.
- Throughput: one bit per cycle while `out_ready` is held high. A vector with k set bits occupies BUSY for exactly k cycles when there is no backpressure.
- Turnaround:
  - The last-bit handshake at edge M returns to IDLE in cycle M+1.
  - The earliest new accept is edge M+1.
  - The next `out_valid` is cycle M+2.
  - This gives a one-cycle bubble between vectors.
- All outputs are functions of registered state only. There is no combinational path from `in_*` or `out_ready` to any output.

## Test plan
- Reset, then idle: after reset, `in_ready`=1, `out_valid`=0, `out_onehot`=0, `out_index`=0. These values hold with `in_valid`=0.
- Single bit: `in_req`=1<<127 with `out_ready`=1.
  - `out_valid` for exactly 1 cycle, with `out_onehot`=1<<127, `out_index`=127, `out_last`=1.
  - `in_ready` returns to 1 the next cycle.
- Multi-bit order: `in_req`=`0x8000_0000_..._0001_0005` (bits 0, 2, 16, 127) with `out_ready`=1.
  - Indices 0, 2, 16, 127 on consecutive cycles.
  - `out_last` only on 127.
- Backpressure: `in_req`=0x6 with `out_ready` low for 3 cycles, then high.
  - `out_index`=1 holds stable for 3 cycles with `out_onehot`=0x2.
  - Then 1 and 2 are emitted; there are no duplicates or losses.
- Zero vector and ignore-while-busy:
  - `in_req`=0 accepted → no `out_valid`, `in_ready` stays 1.
  - `in_valid` with `in_req`=0xF0 during BUSY → ignored, and the current vector completes unchanged.
- Reset mid-vector: `in_req`=all-ones, assert `reset` after 5 words.
  - The next cycle has `out_valid`=0 and `in_ready`=1.
  - A new `in_req`=0x8 yields only `out_index`=3.
